// File: rtl/digit_frame_ctrl_pkg.sv
// Shared definitions for the digit frame controller: FSM state encoding,
// frame_cnt phase codes, the result width and a small counter helper.
package digit_frame_ctrl_pkg;

   localparam int DIGIT_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PROJ  = 2'd1,
      ST_RECOG = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   // Phase codes presented on frame_cnt to the projection/recognition stages
   localparam logic [1:0] FC_PROJ  = 2'd0;
   localparam logic [1:0] FC_RECOG = 2'd1;
   localparam logic [1:0] FC_CHECK = 2'd2;

   // Two-bit counter increment that sticks at its maximum
   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'd3) ? 2'd3 : v + 2'd1;
   endfunction

endpackage

// File: rtl/vip_edge_det.sv
// Rising-edge detector: compares the input against a one-cycle registered
// copy and produces a single-cycle pulse on each 0->1 transition.
module vip_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_d;

   // Delay the input by one clock for the edge comparison
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sig_d <= 1'b0;
      else        r_sig_d <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/digit_frame_ctrl.sv
// Digit frame controller: sequences projection, recognition and a one-cycle
// consistency check across video frames, publishing a digit result only
// after it has been captured identically on several consecutive frames.
module digit_frame_ctrl
   import digit_frame_ctrl_pkg::*;
#(
   parameter int NUM_ROW     = 1,
   parameter int NUM_COL     = 4,
   parameter int STABLE_CNT  = 3,
   parameter int TIMEOUT_FRM = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 frame_vsync,
   input  logic                 project_done_flag,
   input  logic [3:0]           num_row,
   input  logic [3:0]           num_col,
   input  logic [DIGIT_W-1:0]   digit_raw,
   output logic [1:0]           frame_cnt,
   output logic                 proj_en,
   output logic                 recog_en,
   output logic [DIGIT_W-1:0]   digit,
   output logic                 digit_valid,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam logic [3:0] ROW_EXP    = 4'(NUM_ROW);
   localparam logic [3:0] COL_EXP    = 4'(NUM_COL);
   localparam logic [1:0] STABLE_LIM = 2'(STABLE_CNT);
   localparam logic [7:0] TO_LIM     = 8'(TIMEOUT_FRM);

   logic w_fs;

   // Registered state and outputs
   state_t              r_state;
   logic [1:0]          r_frame_cnt;
   logic                r_proj_en;
   logic                r_recog_en;
   logic [DIGIT_W-1:0]  r_digit;
   logic                r_digit_valid;
   logic                r_busy;
   logic                r_err_timeout;
   // Internal bookkeeping
   logic                r_done_lat;
   logic [7:0]          r_to_cnt;
   logic [1:0]          r_stable;
   logic [DIGIT_W-1:0]  r_prev_cap;
   logic                r_prev_vld;
   logic [DIGIT_W-1:0]  r_cap_digit;
   logic [3:0]          r_cap_row;
   logic [3:0]          r_cap_col;

   // Next-state values
   state_t              w_state_nxt;
   logic [1:0]          w_frame_cnt_nxt;
   logic                w_proj_en_nxt;
   logic                w_recog_en_nxt;
   logic [DIGIT_W-1:0]  w_digit_nxt;
   logic                w_digit_valid_nxt;
   logic                w_busy_nxt;
   logic                w_err_nxt;
   logic                w_done_lat_nxt;
   logic [7:0]          w_to_cnt_nxt;
   logic [1:0]          w_stable_nxt;
   logic [1:0]          w_stable_cand;
   logic [DIGIT_W-1:0]  w_prev_cap_nxt;
   logic                w_prev_vld_nxt;
   logic [DIGIT_W-1:0]  w_cap_digit_nxt;
   logic [3:0]          w_cap_row_nxt;
   logic [3:0]          w_cap_col_nxt;
   logic [7:0]          w_to_inc;

   vip_edge_det u_fs_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (frame_vsync),
      .o_rise (w_fs)
   );

   assign w_to_inc = r_to_cnt + 8'd1;

   // Next-state and next-output decode for the frame sequencer
   always_comb begin
      w_state_nxt       = r_state;
      w_frame_cnt_nxt   = r_frame_cnt;
      w_proj_en_nxt     = r_proj_en;
      w_recog_en_nxt    = r_recog_en;
      w_digit_nxt       = r_digit;
      w_digit_valid_nxt = 1'b0;
      w_err_nxt         = 1'b0;
      w_done_lat_nxt    = r_done_lat;
      w_to_cnt_nxt      = r_to_cnt;
      w_stable_nxt      = r_stable;
      w_stable_cand     = 2'd1;
      w_prev_cap_nxt    = r_prev_cap;
      w_prev_vld_nxt    = r_prev_vld;
      w_cap_digit_nxt   = r_cap_digit;
      w_cap_row_nxt     = r_cap_row;
      w_cap_col_nxt     = r_cap_col;

      if (w_fs && !enable) begin
         // A frame start without a run request parks the block; the last
         // published result is kept, but stability must be rebuilt.
         w_state_nxt     = ST_IDLE;
         w_frame_cnt_nxt = FC_PROJ;
         w_proj_en_nxt   = 1'b0;
         w_recog_en_nxt  = 1'b0;
         w_stable_nxt    = 2'd0;
         w_done_lat_nxt  = 1'b0;
         w_to_cnt_nxt    = 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fs) begin
                  w_state_nxt     = ST_PROJ;
                  w_frame_cnt_nxt = FC_PROJ;
                  w_proj_en_nxt   = 1'b1;
                  w_recog_en_nxt  = 1'b0;
                  w_to_cnt_nxt    = 8'd0;
                  w_done_lat_nxt  = 1'b0;
               end
            end
            ST_PROJ: begin
               if (project_done_flag) w_done_lat_nxt = 1'b1;
               if (w_fs) begin
                  // A done arriving with the frame start counts as done first
                  if (r_done_lat || project_done_flag) begin
                     w_state_nxt     = ST_RECOG;
                     w_frame_cnt_nxt = FC_RECOG;
                     w_proj_en_nxt   = 1'b0;
                     w_recog_en_nxt  = 1'b1;
                     w_done_lat_nxt  = 1'b0;
                     w_to_cnt_nxt    = 8'd0;
                  end else if (w_to_inc >= TO_LIM) begin
                     // Projection stalled: flag it and start projecting afresh
                     w_err_nxt       = 1'b1;
                     w_stable_nxt    = 2'd0;
                     w_to_cnt_nxt    = 8'd0;
                     w_frame_cnt_nxt = FC_PROJ;
                     w_proj_en_nxt   = 1'b1;
                     w_recog_en_nxt  = 1'b0;
                  end else begin
                     w_to_cnt_nxt = w_to_inc;
                  end
               end
            end
            ST_RECOG: begin
               if (w_fs) begin
                  w_cap_digit_nxt = digit_raw;
                  w_cap_row_nxt   = num_row;
                  w_cap_col_nxt   = num_col;
                  w_state_nxt     = ST_CHECK;
                  w_frame_cnt_nxt = FC_CHECK;
                  w_proj_en_nxt   = 1'b0;
                  w_recog_en_nxt  = 1'b0;
               end
            end
            ST_CHECK: begin
               w_state_nxt     = ST_PROJ;
               w_frame_cnt_nxt = FC_PROJ;
               w_proj_en_nxt   = 1'b1;
               w_recog_en_nxt  = 1'b0;
               w_done_lat_nxt  = 1'b0;
               w_to_cnt_nxt    = 8'd0;
               if (r_cap_row != ROW_EXP || r_cap_col != COL_EXP) begin
                  w_stable_nxt = 2'd0;
               end else begin
                  if (r_prev_vld && (r_cap_digit == r_prev_cap))
                     w_stable_cand = sat_inc2(r_stable);
                  w_stable_nxt   = w_stable_cand;
                  w_prev_cap_nxt = r_cap_digit;
                  w_prev_vld_nxt = 1'b1;
                  // Only a changed result is announced
                  if (w_stable_cand >= STABLE_LIM && r_cap_digit != r_digit) begin
                     w_digit_nxt       = r_cap_digit;
                     w_digit_valid_nxt = 1'b1;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State, output and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_frame_cnt   <= FC_PROJ;
         r_proj_en     <= 1'b0;
         r_recog_en    <= 1'b0;
         r_digit       <= '0;
         r_digit_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_done_lat    <= 1'b0;
         r_to_cnt      <= 8'd0;
         r_stable      <= 2'd0;
         r_prev_cap    <= '0;
         r_prev_vld    <= 1'b0;
         r_cap_digit   <= '0;
         r_cap_row     <= 4'd0;
         r_cap_col     <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_frame_cnt   <= w_frame_cnt_nxt;
         r_proj_en     <= w_proj_en_nxt;
         r_recog_en    <= w_recog_en_nxt;
         r_digit       <= w_digit_nxt;
         r_digit_valid <= w_digit_valid_nxt;
         r_busy        <= w_busy_nxt;
         r_err_timeout <= w_err_nxt;
         r_done_lat    <= w_done_lat_nxt;
         r_to_cnt      <= w_to_cnt_nxt;
         r_stable      <= w_stable_nxt;
         r_prev_cap    <= w_prev_cap_nxt;
         r_prev_vld    <= w_prev_vld_nxt;
         r_cap_digit   <= w_cap_digit_nxt;
         r_cap_row     <= w_cap_row_nxt;
         r_cap_col     <= w_cap_col_nxt;
      end
   end

   assign frame_cnt   = r_frame_cnt;
   assign proj_en     = r_proj_en;
   assign recog_en    = r_recog_en;
   assign digit       = r_digit;
   assign digit_valid = r_digit_valid;
   assign busy        = r_busy;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_digit_frame_ctrl.sv
// Bench for digit_frame_ctrl: a table of capture sequences with hand-derived
// expectations, hand-written corner sequences, and randomized frames checked
// every cycle against a phase-level reference model.
module tb_digit_frame_ctrl;

   localparam int NUM_ROW     = 1;
   localparam int NUM_COL     = 4;
   localparam int STABLE_CNT  = 3;
   localparam int TIMEOUT_FRM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        frame_vsync = 1'b0;
   logic        project_done_flag = 1'b0;
   logic [3:0]  num_row = 4'd0;
   logic [3:0]  num_col = 4'd0;
   logic [23:0] digit_raw = 24'd0;
   logic [1:0]  frame_cnt;
   logic        proj_en;
   logic        recog_en;
   logic [23:0] digit;
   logic        digit_valid;
   logic        busy;
   logic        err_timeout;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid_seen = 0;
   int n_err_seen = 0;

   always #5 clk = ~clk;

   digit_frame_ctrl #(
      .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL),
      .STABLE_CNT(STABLE_CNT), .TIMEOUT_FRM(TIMEOUT_FRM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_vsync(frame_vsync),
      .project_done_flag(project_done_flag), .num_row(num_row), .num_col(num_col),
      .digit_raw(digit_raw), .frame_cnt(frame_cnt), .proj_en(proj_en),
      .recog_en(recog_en), .digit(digit), .digit_valid(digit_valid),
      .busy(busy), .err_timeout(err_timeout)
   );

   // ---------------- reference model (phase level) ----------------
   localparam int M_IDLE = 0, M_PROJ = 1, M_RECOG = 2, M_CHECK = 3;
   int          m_phase;
   bit          m_vs_q;
   bit          m_done;
   int          m_fs_wait;
   logic [23:0] m_digit;
   bit          m_valid;
   bit          m_err;
   logic [23:0] m_cap;
   int          m_cap_row;
   int          m_cap_col;
   logic [23:0] hist[$];

   task automatic model_reset();
      m_phase = M_IDLE; m_vs_q = 0; m_done = 0; m_fs_wait = 0;
      m_digit = 24'd0; m_valid = 0; m_err = 0;
      m_cap = 24'd0; m_cap_row = 0; m_cap_col = 0;
      hist.delete();
   endtask

   function automatic bit hist_stable();
      if (hist.size() < STABLE_CNT) return 0;
      for (int i = 1; i < hist.size(); i++)
         if (hist[i] != hist[0]) return 0;
      return 1;
   endfunction

   task automatic model_clk();
      bit fs;
      if (!rst_n) begin model_reset(); return; end
      fs = frame_vsync && !m_vs_q;
      m_vs_q = frame_vsync;
      m_valid = 0;
      m_err = 0;
      if (fs && !enable) begin
         m_phase = M_IDLE; m_done = 0; m_fs_wait = 0; hist.delete();
      end else begin
         case (m_phase)
            M_IDLE: if (fs) begin m_phase = M_PROJ; m_done = 0; m_fs_wait = 0; end
            M_PROJ: begin
               if (project_done_flag) m_done = 1;
               if (fs) begin
                  if (m_done) begin
                     m_phase = M_RECOG; m_done = 0;
                  end else begin
                     m_fs_wait++;
                     if (m_fs_wait == TIMEOUT_FRM) begin
                        m_err = 1; m_fs_wait = 0; hist.delete();
                     end
                  end
               end
            end
            M_RECOG: if (fs) begin
               m_cap = digit_raw; m_cap_row = num_row; m_cap_col = num_col;
               m_phase = M_CHECK;
            end
            default: begin
               m_phase = M_PROJ; m_done = 0; m_fs_wait = 0;
               if (m_cap_row != NUM_ROW || m_cap_col != NUM_COL) begin
                  hist.delete();
               end else begin
                  hist.push_back(m_cap);
                  if (hist.size() > STABLE_CNT) void'(hist.pop_front());
                  if (hist_stable() && m_cap != m_digit) begin
                     m_digit = m_cap; m_valid = 1;
                  end
               end
            end
         endcase
      end
   endtask

   function automatic logic [63:0] model_vec();
      logic [1:0] fc;
      fc = (m_phase == M_RECOG) ? 2'd1 : (m_phase == M_CHECK) ? 2'd2 : 2'd0;
      return {33'd0, fc, m_phase == M_PROJ, m_phase == M_RECOG, m_digit,
              m_valid, m_phase != M_IDLE, m_err};
   endfunction

   function automatic logic [63:0] dut_vec();
      return {33'd0, frame_cnt, proj_en, recog_en, digit, digit_valid, busy, err_timeout};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_clk();
      if (digit_valid === 1'b1) n_valid_seen++;
      if (err_timeout === 1'b1) n_err_seen++;
      check("cycle", dut_vec(), model_vec());
   endtask

   task automatic frame(input bit en, input int done_pos, input logic [23:0] raw,
                        input logic [3:0] row, input logic [3:0] col,
                        input int hi, input int len);
      enable = en; digit_raw = raw; num_row = row; num_col = col;
      for (int i = 0; i < len; i++) begin
         frame_vsync = (i < hi);
         project_done_flag = (i == done_pos);
         tick();
      end
      project_done_flag = 1'b0;
      frame_vsync = 1'b0;
   endtask

   // ---------------- table of capture sequences ----------------
   typedef struct {
      logic [23:0] raw;
      logic [3:0]  col;
      bit          exp_pulse;
      logic [23:0] exp_digit;
   } vec_t;
   vec_t tbl[14];

   initial begin
      int v0;
      int e0;
      bit en;
      int hi;
      int len;
      int dpos;
      logic [23:0] raw;
      logic [3:0]  row;
      logic [3:0]  col;

      tbl[0]  = '{24'h001234, 4'd4, 1'b0, 24'h000000};
      tbl[1]  = '{24'h001234, 4'd4, 1'b0, 24'h000000};
      tbl[2]  = '{24'h001234, 4'd4, 1'b1, 24'h001234};
      tbl[3]  = '{24'h001234, 4'd4, 1'b0, 24'h001234};
      tbl[4]  = '{24'h001234, 4'd4, 1'b0, 24'h001234};
      tbl[5]  = '{24'h005678, 4'd4, 1'b0, 24'h001234};
      tbl[6]  = '{24'h005678, 4'd4, 1'b0, 24'h001234};
      tbl[7]  = '{24'h005678, 4'd4, 1'b1, 24'h005678};
      tbl[8]  = '{24'h001234, 4'd4, 1'b0, 24'h005678};
      tbl[9]  = '{24'h001234, 4'd4, 1'b0, 24'h005678};
      tbl[10] = '{24'h001234, 4'd3, 1'b0, 24'h005678};
      tbl[11] = '{24'h001234, 4'd4, 1'b0, 24'h005678};
      tbl[12] = '{24'h001234, 4'd4, 1'b0, 24'h005678};
      tbl[13] = '{24'h001234, 4'd4, 1'b1, 24'h001234};

      model_reset();
      tick();
      tick();
      check("reset_state", dut_vec(), 64'd0);
      rst_n = 1'b1;
      tick();

      // Enter PROJ with done in the first frame, then alternate RECOG / capture frames
      frame(1'b1, 2, 24'h0, 4'd1, 4'd4, 2, 8);
      check("enter_proj", {frame_cnt, proj_en, recog_en, busy}, {2'd0, 1'b1, 1'b0, 1'b1});
      for (int k = 0; k < 14; k++) begin
         frame(1'b1, -1, 24'h0, 4'd1, 4'd4, 2, 8);
         v0 = n_valid_seen;
         frame(1'b1, 4, tbl[k].raw, 4'd1, tbl[k].col, 2, 8);
         check($sformatf("tbl%0d_pulses", k), 64'(n_valid_seen - v0), 64'(tbl[k].exp_pulse));
         check($sformatf("tbl%0d_digit", k), 64'(digit), 64'(tbl[k].exp_digit));
      end

      // Disable at a frame start: back to idle, result held
      frame(1'b0, -1, 24'h0, 4'd1, 4'd4, 2, 8);
      check("dis_idle", {frame_cnt, proj_en, recog_en, busy}, 5'b0);
      check("dis_digit_held", 64'(digit), 64'h001234);

      // Projection timeout: no done for TIMEOUT_FRM frame starts
      frame(1'b1, -1, 24'h0, 4'd1, 4'd4, 2, 8);
      e0 = n_err_seen;
      for (int f = 0; f < TIMEOUT_FRM - 1; f++) frame(1'b1, -1, 24'h0, 4'd1, 4'd4, 2, 8);
      check("to_none_early", 64'(n_err_seen - e0), 64'd0);
      frame(1'b1, -1, 24'h0, 4'd1, 4'd4, 2, 8);
      check("to_one_pulse", 64'(n_err_seen - e0), 64'd1);
      check("to_stay_proj", {frame_cnt, proj_en, recog_en, busy}, {2'd0, 1'b1, 1'b0, 1'b1});

      // Done and frame start in the same cycle
      enable = 1'b1;
      frame_vsync = 1'b1;
      project_done_flag = 1'b1;
      tick();
      project_done_flag = 1'b0;
      check("same_cyc_recog", {frame_cnt, proj_en, recog_en}, {2'd1, 1'b0, 1'b1});
      tick();
      frame_vsync = 1'b0;
      tick();
      tick();

      // Asynchronous reset in the middle of RECOG
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_outputs", dut_vec(), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      frame_vsync = 1'b1;
      tick();
      check("post_rst_proj", {frame_cnt, proj_en, recog_en, busy}, {2'd0, 1'b1, 1'b0, 1'b1});
      frame_vsync = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Randomized frames against the reference model
      for (int f = 0; f < 250; f++) begin
         en   = ($urandom_range(0, 9) != 0);
         hi   = $urandom_range(1, 3);
         len  = $urandom_range(hi + 1, 9);
         dpos = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, len - 1));
         case ($urandom_range(0, 3))
            0, 1:    raw = 24'h001234;
            2:       raw = 24'h005678;
            default: raw = 24'($urandom);
         endcase
         row = ($urandom_range(0, 7) == 0) ? 4'd2 : 4'd1;
         col = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd4;
         frame(en, dpos, raw, row, col, hi, len);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
